// File: rtl/corr_peak_finder.sv
// corr_peak_finder: scans one window of SAMPLES*OSF magnitudes and loads the
// index of the largest qualifying sample (or N for none) into the result register.
module corr_peak_finder #(
    parameter int SAMPLES = 128,
    parameter int OSF = 8,
    parameter int DW = 32,
    localparam int IW = $clog2(SAMPLES * OSF) + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InValid,
    input  logic [DW-1:0] InCorr,
    input  logic [DW-1:0] Threshold,
    output logic [IW-1:0] PeakIndex,
    output logic [DW-1:0] PeakValue,
    output logic          LD,
    output logic          Found,
    output logic          Busy
);
    localparam int N = SAMPLES * OSF;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] NONE = IW'(N);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, next_state;
    logic [IW-1:0] count, run_idx, nxt_idx;
    logic [DW-1:0] run_max, thr_q, nxt_max;
    logic run_found, nxt_found, accept, qual, ld_d, busy_d;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        accept = state == SCAN && InValid;
        next_state = state == IDLE ? (Start ? SCAN : IDLE) :
                     state == SCAN ? ((accept && count == LAST) ? DONE : SCAN) : IDLE;
    end

    // Strict '>' against the running max keeps the earliest index on ties.
    always_comb begin
        qual = accept && InCorr >= thr_q && (!run_found || InCorr > run_max);
        nxt_max = qual ? InCorr : run_max;
        nxt_idx = qual ? count : run_idx;
        nxt_found = run_found || qual;
        ld_d = next_state == DONE;
        busy_d = next_state != IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_found <= 1'b0;
            thr_q <= '0;
            PeakIndex <= '0;
            PeakValue <= '0;
            LD <= 1'b0;
            Found <= 1'b0;
            Busy <= 1'b0;
        end else begin
            LD <= ld_d;
            Busy <= busy_d;
            if (state == IDLE && Start) begin
                count <= '0;
                run_max <= '0;
                run_idx <= '0;
                run_found <= 1'b0;
                thr_q <= Threshold;
            end else if (accept) begin
                count <= count == LAST ? '0 : count + 1'b1;
                run_max <= nxt_max;
                run_idx <= nxt_idx;
                run_found <= nxt_found;
            end
            // Results change on the same edge that raises LD.
            if (ld_d) begin
                PeakIndex <= nxt_found ? nxt_idx : NONE;
                PeakValue <= nxt_found ? nxt_max : '0;
                Found <= nxt_found;
            end
        end
    end
endmodule
